// File: rtl/sim_status_reporter.sv
// Simulation status channel producer: queues 32-bit report words, paces them onto
// sim_report with a strobe, then latches a sticky done/verdict, with a watchdog fail-safe.
module sim_status_reporter #(
   parameter int          DEPTH        = 4,
   parameter int          HOLD         = 4,
   parameter int          TIMEOUT      = 100000,
   parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   input  logic        finish,
   input  logic        finish_pass,
   output logic [31:0] sim_report,
   output logic        sim_report_stb,
   output logic        sim_done,
   output logic        sim_success,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DONE} state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     mem_d [DEPTH];
   logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [31:0]     wd_q, wd_d;
   logic [31:0]     rep_q, rep_d;
   logic            stb_q, stb_d;
   logic            done_q, done_d;
   logic            succ_q, succ_d;
   logic            fin_pend_q, fin_pend_d;
   logic            fin_pass_q, fin_pass_d;

   logic push, pop, empty, full, wd_exp;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign wr_ready = !full && (state_q != ST_DONE);
   assign push     = wr_valid && wr_ready;
   assign wd_exp   = (TIMEOUT != 0) && (state_q != ST_DONE) && (wd_q == 32'(TIMEOUT - 1));

   assign sim_report     = rep_q;
   assign sim_report_stb = stb_q;
   assign sim_done       = done_q;
   assign sim_success    = succ_q;
   assign busy           = !empty || (state_q == ST_HOLD);

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      hold_cnt_d = hold_cnt_q;
      wd_d       = wd_q;
      rep_d      = rep_q;
      stb_d      = 1'b0;
      done_d     = done_q;
      succ_d     = succ_q;
      fin_pend_d = fin_pend_q;
      fin_pass_d = fin_pass_q;
      pop        = 1'b0;

      if (push) begin
         mem_d[wptr_q] = wr_data;
         wptr_d        = wptr_q + 1'b1;
      end
      if (state_q != ST_DONE && finish && !fin_pend_q) begin
         fin_pend_d = 1'b1;
         fin_pass_d = finish_pass;
      end
      if (TIMEOUT != 0 && state_q != ST_DONE) wd_d = wd_q + 32'd1;

      case (state_q)
         ST_IDLE: begin
            if (!empty) pop = 1'b1;
            else if (fin_pend_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               succ_d  = fin_pass_q;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 1'b1;
            else if (!empty) pop = 1'b1;
            else if (fin_pend_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               succ_d  = fin_pass_q;
            end else state_d = ST_IDLE;
         end
         default: ;
      endcase

      if (pop) begin
         rep_d      = mem_q[rptr_q];
         stb_d      = 1'b1;
         rptr_d     = rptr_q + 1'b1;
         hold_cnt_d = HW'(HOLD - 1);
         state_d    = ST_HOLD;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // Watchdog expiry beats any pop, push or verdict decided in the same cycle.
      if (wd_exp) begin
         state_d = ST_DONE;
         rep_d   = TIMEOUT_CODE;
         stb_d   = 1'b1;
         done_d  = 1'b1;
         succ_d  = 1'b0;
         count_d = '0;
         rptr_d  = '0;
         wptr_d  = '0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_q      <= '{default: '0};
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         hold_cnt_q <= '0;
         wd_q       <= '0;
         rep_q      <= '0;
         stb_q      <= 1'b0;
         done_q     <= 1'b0;
         succ_q     <= 1'b0;
         fin_pend_q <= 1'b0;
         fin_pass_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         hold_cnt_q <= hold_cnt_d;
         wd_q       <= wd_d;
         rep_q      <= rep_d;
         stb_q      <= stb_d;
         done_q     <= done_d;
         succ_q     <= succ_d;
         fin_pend_q <= fin_pend_d;
         fin_pass_q <= fin_pass_d;
      end
   end

endmodule

// File: tb/tb_sim_status_reporter.sv
// Directed bench for sim_status_reporter: cycle table plus hand sequences for
// backpressure, watchdog expiry, finish-vs-watchdog and mid-hold reset.
module tb_sim_status_reporter;

   logic        refclk = 1'b0;
   logic        rst = 1'b0, wr_valid = 1'b0, finish = 1'b0, finish_pass = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready, sim_report_stb, sim_done, sim_success, busy;
   logic [31:0] sim_report;

   int n_checks = 0;
   int n_err    = 0;

   sim_status_reporter #(.DEPTH(4), .HOLD(4), .TIMEOUT(50), .TIMEOUT_CODE(32'hDEAD_0001)) dut (
      .refclk(refclk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .finish(finish), .finish_pass(finish_pass), .sim_report(sim_report),
      .sim_report_stb(sim_report_stb), .sim_done(sim_done), .sim_success(sim_success), .busy(busy)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic        rst, wv;
      logic [31:0] wd;
      logic        fin, fp;
      logic        stb;
      logic [31:0] rep;
      logic        done, succ, rdy, bsy;
   } vec_t;

   vec_t tbl[$];

   task automatic step(input logic r, input logic v, input logic [31:0] d, input logic f, input logic fp);
      rst = r; wr_valid = v; wr_data = d; finish = f; finish_pass = fp;
      @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int idx, input logic stb, input logic [31:0] rep,
                           input logic done, input logic succ, input logic rdy, input logic bsy);
      chk({tag, ".stb"},  idx, {31'd0, sim_report_stb}, {31'd0, stb});
      chk({tag, ".rep"},  idx, sim_report, rep);
      chk({tag, ".done"}, idx, {31'd0, sim_done}, {31'd0, done});
      chk({tag, ".succ"}, idx, {31'd0, sim_success}, {31'd0, succ});
      chk({tag, ".rdy"},  idx, {31'd0, wr_ready}, {31'd0, rdy});
      chk({tag, ".busy"}, idx, {31'd0, busy}, {31'd0, bsy});
   endtask

   logic [31:0] words [6];
   int          sent, nstb, last_stb;
   logic        v, saw_full;

   initial begin
      // rst  wv  wd            fin  fp   | stb rep            done succ rdy busy
      tbl.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b0});
      tbl.push_back('{1'b0,1'b1,32'h11, 1'b0,1'b0, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b1,32'h22, 1'b0,1'b0, 1'b1,32'h11, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b1,32'h33, 1'b0,1'b0, 1'b0,32'h11, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h11, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h11, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h22, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h22, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h22, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h22, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h33, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h33, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h33, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h33, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h33, 1'b0,1'b0,1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b1,1'b1, 1'b0,32'h33, 1'b0,1'b0,1'b1,1'b0});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h33, 1'b1,1'b1,1'b0,1'b0});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b0,32'h33, 1'b1,1'b1,1'b0,1'b0});
      tbl.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b0});
      tbl.push_back('{1'b0,1'b1,32'hA5, 1'b1,1'b1, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b1,1'b0, 1'b1,32'hA5, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'hA5, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'hA5, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'hA5, 1'b0,1'b0,1'b1,1'b1});
      tbl.push_back('{1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'hA5, 1'b1,1'b1,1'b0,1'b0});
      tbl.push_back('{1'b0,1'b1,32'h99, 1'b0,1'b0, 1'b0,32'hA5, 1'b1,1'b1,1'b0,1'b0});

      #2;
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].fin, tbl[i].fp);
         chk_outs("tbl", i, tbl[i].stb, tbl[i].rep, tbl[i].done, tbl[i].succ, tbl[i].rdy, tbl[i].bsy);
      end

      // Six words against a four-deep FIFO: backpressure, order and 4-cycle pacing.
      for (int i = 0; i < 6; i++) words[i] = 32'h100 + 32'(i);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      sent = 0; nstb = 0; last_stb = 0; saw_full = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         v = (sent < 6);
         if (v && wr_ready) begin
            step(1'b0, 1'b1, words[sent], 1'b0, 1'b0);
            sent++;
         end else step(1'b0, v, (sent < 6) ? words[sent] : 32'h0, 1'b0, 1'b0);
         if (!wr_ready) saw_full = 1'b1;
         if (sim_report_stb) begin
            if (nstb < 6) chk("bp.word", nstb, sim_report, words[nstb]);
            if (nstb > 0) chk("bp.gap", nstb, 32'(c - last_stb), 32'd4);
            last_stb = c;
            nstb++;
         end
      end
      chk("bp.strobes", 0, 32'(nstb), 32'd6);
      chk("bp.sent", 0, 32'(sent), 32'd6);
      chk("bp.full_seen", 0, {31'd0, saw_full}, 32'd1);

      // Watchdog expiry with two words queued during a hold.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 1; k <= 51; k++) begin
         step(1'b0, (k == 46 || k == 48 || k == 49), 32'hC0 + 32'(k), 1'b0, 1'b0);
         if (k == 49) chk_outs("wd49", k, 1'b0, 32'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
         if (k == 50) chk_outs("wd50", k, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 1'b0);
         if (k == 51) chk_outs("wd51", k, 1'b0, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Passing finish landing on the expiry cycle still yields a failing verdict.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 1; k <= 51; k++) begin
         step(1'b0, 1'b0, '0, (k == 50), 1'b1);
         if (k == 49) chk_outs("wf49", k, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (k == 50) chk_outs("wf50", k, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 1'b0);
         if (k == 51) chk_outs("wf51", k, 1'b0, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Reset during a hold with three words queued, then a fresh word.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 32'h50 + 32'(k), 1'b0, 1'b0);
      chk_outs("mr.pre", 4, 1'b0, 32'h51, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk_outs("mr.rst", 5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
      chk_outs("mr.push", 6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk_outs("mr.pop", 7, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk_outs("mr.hold", 8, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
